// File: rtl/cmp_hysteresis_switch.sv
// cmp_hysteresis_switch: debounced on/off command from comparator flags, with a post-switch dwell lockout
module cmp_hysteresis_switch #(
  parameter int CONFIRM_N = 3,
  parameter int CNT_W     = 4,
  parameter int MIN_HOLD  = 100,
  parameter int HOLD_W    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sta,
  input  logic agb,
  input  logic alb,
  output logic switch_out,
  output logic switch_pulse,
  output logic done_sig,
  output logic err_both
);
  typedef enum logic {OFF, ON} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [HOLD_W-1:0] dwell_q, dwell_d;
  logic pulse_q, pulse_d, done_q, err_q, err_d, qual, fire, locked;
  always_comb begin
    locked  = dwell_q != '0;
    qual    = sta & (state_q == ON ? alb & ~agb : agb & ~alb);
    fire    = qual & ~locked & (cnt_q == CNT_W'(CONFIRM_N - 1));
    state_d = fire ? (state_q == ON ? OFF : ON) : state_q;
    // any valid sample that cannot advance the count (oppose, neither, both, or inside dwell) clears it
    cnt_d   = !sta ? cnt_q : (!qual || locked || fire) ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
    dwell_d = fire ? HOLD_W'(MIN_HOLD) : locked ? dwell_q - 1'b1 : dwell_q;
    pulse_d = fire;
    err_d   = sta & agb & alb;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= OFF;
      cnt_q   <= '0;
      dwell_q <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      pulse_q <= pulse_d;
      done_q  <= sta;
      err_q   <= err_d;
    end
  end
  assign switch_out   = state_q == ON;
  assign switch_pulse = pulse_q;
  assign done_sig     = done_q;
  assign err_both     = err_q;
endmodule

// File: tb/tb_cmp_hysteresis_switch.sv
// tb_cmp_hysteresis_switch: scoreboard bench driving a default and a CONFIRM_N=1/MIN_HOLD=0 instance in parallel
module tb_cmp_hysteresis_switch;
  logic clk = 0, rst = 0, sta = 0, agb = 0, alb = 0;
  logic so0, sp0, dn0, eb0, so1, sp1, dn1, eb1;
  int cyc = 0, checks = 0, passes = 0;
  typedef struct { int due; logic [7:0] exp; } rec_t;
  rec_t q[$];
  rec_t m;
  int st[2], cnt[2], dw[2];
  int cn[2] = '{3, 1};
  int mh[2] = '{100, 0};

  cmp_hysteresis_switch dut0 (.clk(clk), .rst(rst), .sta(sta), .agb(agb), .alb(alb),
    .switch_out(so0), .switch_pulse(sp0), .done_sig(dn0), .err_both(eb0));
  cmp_hysteresis_switch #(.CONFIRM_N(1), .CNT_W(4), .MIN_HOLD(0), .HOLD_W(16)) dut1 (
    .clk(clk), .rst(rst), .sta(sta), .agb(agb), .alb(alb),
    .switch_out(so1), .switch_pulse(sp1), .done_sig(dn1), .err_both(eb1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    while (q.size() > 0 && q[0].due <= cyc) begin
      m = q.pop_front();
      checks += 2;
      if ({dn0, so0, sp0, eb0} == m.exp[3:0]) passes++;
      else $display("FAIL dflt cyc=%0d {done,sw,pulse,err} got=%b want=%b", cyc, {dn0, so0, sp0, eb0}, m.exp[3:0]);
      if ({dn1, so1, sp1, eb1} == m.exp[7:4]) passes++;
      else $display("FAIL corner cyc=%0d {done,sw,pulse,err} got=%b want=%b", cyc, {dn1, so1, sp1, eb1}, m.exp[7:4]);
    end

  // Reference: a sample qualifies when it points away from the current state;
  // CONFIRM_N in a row outside the dwell window flips the state and opens a new window.
  task automatic step(input logic r, input logic s, input logic a, input logic b);
    logic [7:0] e;
    @(negedge clk);
    rst = r; sta = s; agb = a; alb = b;
    for (int i = 0; i < 2; i++) begin
      bit p = 0, flip = 0;
      if (!r) begin
        st[i] = 0; cnt[i] = 0; dw[i] = 0;
      end else begin
        if (s) begin
          bit want = st[i] ? (b && !a) : (a && !b);
          if (want && dw[i] == 0) begin
            if (cnt[i] + 1 >= cn[i]) flip = 1;
            else cnt[i]++;
          end else cnt[i] = 0;
        end
        dw[i] = flip ? mh[i] : (dw[i] > 0 ? dw[i] - 1 : 0);
        if (flip) begin st[i] = 1 - st[i]; cnt[i] = 0; p = 1; end
      end
      e[i*4 +: 4] = {r & s, st[i] == 1, p, r & s & a & b};
    end
    q.push_back('{cyc + 1, e});
  endtask

  task automatic idle(input int n);
    repeat (n) step(1, 0, 0, 0);
  endtask

  initial begin
    int mode = 0;
    repeat (2) step(0, 1, 1, 0);
    repeat (3) step(1, 1, 1, 0);
    repeat (110) step(1, 1, 0, 1);
    idle(105);
    step(1, 1, 1, 0); step(1, 1, 1, 0); step(1, 1, 0, 0); step(1, 1, 1, 0); step(1, 1, 1, 0); step(1, 1, 1, 0);
    idle(101);
    repeat (4) begin idle(6); step(1, 1, 0, 1); end
    idle(101);
    step(1, 1, 1, 0); step(1, 1, 1, 0); step(1, 1, 1, 1); step(1, 1, 1, 0); step(1, 1, 1, 0); step(1, 1, 1, 0);
    idle(50);
    step(0, 0, 0, 0);
    repeat (3) step(1, 1, 1, 0);
    idle(101);
    for (int i = 0; i < 20; i++) step(1, 1, i % 2 == 0, i % 2 == 1);
    for (int i = 0; i < 3000; i++) begin
      int k;
      if (i % 40 == 0) mode = $urandom_range(0, 1);
      k = $urandom_range(0, 9);
      step($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0,
           mode == 0 ? k < 6 : k < 2,
           mode == 0 ? (k == 0 || k >= 8) : (k == 1 || k >= 4));
    end
    idle(3);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() <= 1) passes++;
    else $display("FAIL drain pending=%0d want<=1", q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/cmp_hysteresis_switch.md
Name: cmp_hysteresis_switch

Overview:
- Consumes the registered agb/alb flags and done strobe of the float comparator stage in the wind-turbine control loop.
- Converts them into a debounced on/off switching command for the converter/pitch control logic.
- Turn-on needs CONFIRM_N consecutive qualifying "greater" results; turn-off needs CONFIRM_N consecutive "less" results.
- After every transition, the opposite transition is locked out for MIN_HOLD clocks.

Parameters:
- CONFIRM_N, 3, consecutive qualifying valid samples required to switch; legal range 1..2^CNT_W-1.
- CNT_W, 4, width of the confirmation counter.
- MIN_HOLD, 100, minimum dwell in clk cycles after a transition; 0 disables the lockout.
- HOLD_W, 16, width of the dwell counter; MIN_HOLD must be ≤ 2^HOLD_W-1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous reset, active-low.
- sta  in  1  sample valid: the comparator done strobe, one cycle per sample.
- agb  in  1  comparator result, input_1 > input_2; sampled only when sta=1.
- alb  in  1  comparator result, input_1 < input_2; sampled only when sta=1.
- switch_out  out  1  registered switching command, 1 = ON.
- switch_pulse  out  1  one-cycle pulse in the cycle switch_out changes.
- done_sig  out  1  sta delayed by one clk; marks that the sample's effect is visible on the outputs.
- err_both  out  1  one-cycle pulse when sta=1 with agb=1 and alb=1 (illegal compare result).

Behaviour:
- Reset is synchronous: rst=0 sampled on a clk rising edge clears everything. Reset is active-low.
  - switch_out=0, switch_pulse=0, done_sig=0, err_both=0.
  - Confirmation counter = 0, dwell counter = 0, state = OFF.
  - Reset mid-count or mid-dwell discards all progress.
- States: OFF and ON. switch_out is the registered state.
- Sample classification, evaluated only when sta=1:
  - qualify = agb&~alb in OFF; alb&~agb in ON.
  - oppose = the other legal flag. This holds the current state and clears the counter.
  - neither (agb=alb=0: equal or NaN): confirmation counter cleared to 0.
  - both (agb=alb=1): treated as neither; err_both=1 on the next cycle.
- Confirmation counter:
  - Incremented on a qualifying sample while dwell=0.
  - Saturates and never wraps.
  - Samples with sta=0 leave the counter unchanged; gaps between valid samples are allowed.
- Transition rule: a qualifying sample arrives while the counter = CONFIRM_N-1 and dwell=0. On the next clk edge:
  - switch_out toggles.
  - switch_pulse=1 for that one cycle.
  - Confirmation counter is cleared to 0.
  - Dwell counter is loaded with MIN_HOLD.
- Latency: sample k at edge t sets switch_out at edge t+1, the same cycle done_sig=1 for that sample.
- Dwell counter:
  - Decrements by 1 every clk while nonzero, independent of sta.
  - While nonzero, qualifying samples do not increment; the confirmation counter is held at 0.
  - Counting resumes with the first valid sample in the cycle where dwell=0.
- Simultaneous events:
  - sta=1 in the same cycle dwell reaches 0 (value 0 at the edge): the sample counts.
  - sta=1 in the cycle the dwell counter still reads 1: the sample is ignored.
- CONFIRM_N=1: every qualifying sample outside dwell switches immediately.
- MIN_HOLD=0: the dwell counter is never loaded; back-to-back transitions on consecutive valid samples are legal.
- done_sig: a pure 1-cycle delay of sta. It is asserted regardless of classification and is not gated by dwell.
- All outputs are registered; no combinational input-to-output path.

Test Plan:
- Reset check: drive rst=0 for 2 cycles with sta=1, agb=1 → all outputs 0. Release, then 3 valid agb samples → switch_out=1 one cycle after the 3rd, switch_pulse=1 in that cycle only.
- Debounce: OFF, valid agb sequence 1,1,(neither),1,1 → no switch. One further agb → switch_out=1. Counter reset by the equal sample is confirmed.
- Dwell lockout, MIN_HOLD=100: switch ON at cycle T, then alb valid every cycle → switch_out stays 1 through cycle T+100. Turn-off occurs exactly when the 3rd alb sample after dwell=0 is taken.
- Sparse valids: sta=1 every 7th cycle with alb=1 in ON, dwell expired → switch_out=0 exactly one cycle after the 3rd valid strobe. done_sig mirrors each strobe one cycle later.
- Illegal input: sta=1, agb=alb=1 after 2 qualifying samples → err_both=1 for 1 cycle, counter cleared. 3 more qualifying samples are needed to switch.
- Reset mid-operation: in ON with dwell=50, assert rst=0 for 1 cycle → switch_out=0 and dwell cleared. Then 3 agb samples switch ON again with no lockout.
- Corner, CONFIRM_N=1 and MIN_HOLD=0: alternating agb/alb valid every cycle → switch_out toggles every cycle, switch_pulse held high continuously.
